// File: rtl/alu_issue_queue.sv
// alu_issue_queue
//   Issue stage in front of the 4-bit add/subtract ALU. Commands {op, a, b}
//   are accepted over a valid/ready handshake into a circular FIFO and issued
//   one per cycle to the ALU. y_valid marks the cycle in which the ALU's
//   registered result belongs to an issued command.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   command present            in_ready  queue can accept (count != DEPTH)
//   in_op      0 = add, 1 = subtract      in_a/in_b operands
//   stall      downstream hold, no issue while high
//   alu_en     one-cycle strobe per issued command (registered)
//   alu_op/a/b issued command fields (registered, hold when idle)
//   y_valid    alu_en delayed one stage
//   count      FIFO occupancy
module alu_issue_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_op,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic                     stall,
    output logic                     alu_en,
    output logic                     alu_op,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic                     y_valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int EW = 1 + 2 * WIDTH;
    localparam logic [PW:0]   FULL    = (PW + 1)'(DEPTH);
    localparam logic [PW:0]   CNT_ONE = 1;
    localparam logic [PW-1:0] PTR_ONE = 1;

    logic [EW-1:0]    mem_q [DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             alu_en_q, alu_en_d;
    logic             alu_op_q, alu_op_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic             y_valid_q, y_valid_d;

    logic             push;
    logic             pop;
    logic [EW-1:0]    head;

    always_comb begin
        // Push and pop are both judged on the pre-edge occupancy, so a pop
        // from a full queue frees its slot only for the following cycle.
        push      = in_valid && (count_q != FULL);
        pop       = (count_q != '0) && !stall;
        head      = mem_q[rd_ptr_q];

        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        alu_en_d  = 1'b0;
        alu_op_d  = alu_op_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        y_valid_d = alu_en_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end

        if (pop) begin
            rd_ptr_d                     = rd_ptr_q + PTR_ONE;
            alu_en_d                     = 1'b1;
            {alu_op_d, alu_a_d, alu_b_d} = head;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Payload storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_op, in_a, in_b};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            alu_en_q  <= 1'b0;
            alu_op_q  <= 1'b0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            y_valid_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            alu_en_q  <= alu_en_d;
            alu_op_q  <= alu_op_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            y_valid_q <= y_valid_d;
        end
    end

    assign in_ready = (count_q != FULL);
    assign count    = count_q;
    assign alu_en   = alu_en_q;
    assign alu_op   = alu_op_q;
    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign y_valid  = y_valid_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue
//   Self-checking bench for alu_issue_queue. A queue-based reference model
//   tracks accepted commands, issue slots and the ALU result; directed
//   scenarios are followed by randomized traffic.
module tb_alu_issue_queue;

    localparam int DEPTH = 4;
    localparam int WIDTH = 4;

    logic             clk;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic             in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             stall;
    logic             alu_en;
    logic             alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             y_valid;
    logic [2:0]       count;

    alu_issue_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_a     (in_a),
        .in_b     (in_b),
        .stall    (stall),
        .alu_en   (alu_en),
        .alu_op   (alu_op),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .y_valid  (y_valid),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic op, input logic [3:0] a, input logic [3:0] b);
        return op ? ({4'b0, a} - {4'b0, b}) : ({4'b0, a} + {4'b0, b});
    endfunction

    // ALU stand-in driven by the DUT's issue outputs.
    logic [7:0] dut_y;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)   dut_y <= 8'h00;
        else if (alu_en) dut_y <= alu_f(alu_op, alu_a, alu_b);
    end

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model
    logic [8:0] q[$];
    logic       m_en, m_op, m_yv;
    logic [3:0] m_a, m_b;
    logic [7:0] m_y;

    task automatic model_reset();
        q.delete();
        m_en = 0; m_op = 0; m_a = 0; m_b = 0; m_yv = 0; m_y = 0;
    endtask

    task automatic model_step();
        logic do_push, do_pop;
        logic [8:0] e;
        if (!reset_n) begin
            model_reset();
            return;
        end
        do_push = in_valid && (q.size() != DEPTH);
        do_pop  = (q.size() != 0) && !stall;
        if (m_en) m_y = alu_f(m_op, m_a, m_b);
        m_yv = m_en;
        if (do_pop) begin
            e = q.pop_front();
            {m_op, m_a, m_b} = e;
            m_en = 1;
        end else begin
            m_en = 0;
        end
        if (do_push) q.push_back({in_op, in_a, in_b});
    endtask

    task automatic compare_all();
        check("count",    count,    q.size());
        check("in_ready", in_ready, q.size() != DEPTH);
        check("alu_en",   alu_en,   m_en);
        check("alu_op",   alu_op,   m_op);
        check("alu_a",    alu_a,    m_a);
        check("alu_b",    alu_b,    m_b);
        check("y_valid",  y_valid,  m_yv);
        check("alu_y",    dut_y,    m_y);
    endtask

    // Called at a falling edge: drive, advance one rising edge, check at the next falling edge.
    task automatic cycle(input logic v, input logic op, input logic [3:0] a, input logic [3:0] b, input logic st);
        in_valid = v; in_op = op; in_a = a; in_b = b; stall = st;
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    int unsigned pulses;
    int unsigned run, max_run;
    int unsigned k;

    initial begin
        reset_n = 0; in_valid = 0; in_op = 0; in_a = 0; in_b = 0; stall = 0;
        model_reset();
        @(negedge clk);

        // Reset state; pushes during reset are ignored.
        check("rst_in_ready", in_ready, 1);
        check("rst_count", count, 0);
        cycle(1, 0, 4'h9, 4'h9, 0);
        cycle(1, 0, 4'h9, 4'h9, 0);
        check("rst_no_push", count, 0);
        reset_n = 1;

        // Add: 3 + 4
        cycle(1, 0, 4'd3, 4'd4, 0);
        check("add_count", count, 1);
        cycle(0, 0, 0, 0, 0);
        check("add_en", alu_en, 1);
        check("add_a", alu_a, 3);
        check("add_b", alu_b, 4);
        cycle(0, 0, 0, 0, 0);
        check("add_yv", y_valid, 1);
        check("add_y", dut_y, 8'h07);

        // Subtract: 2 - 5
        cycle(1, 1, 4'd2, 4'd5, 0);
        cycle(0, 0, 0, 0, 0);
        check("sub_op", alu_op, 1);
        cycle(0, 0, 0, 0, 0);
        check("sub_yv", y_valid, 1);
        check("sub_y", dut_y, 8'hFD);

        // Stall while pushing five commands; fifth stays pending.
        for (int i = 0; i < 5; i++) cycle(1, 0, 4'(i + 1), 4'(i + 6), 1);
        check("stall_full_count", count, 4);
        check("stall_full_ready", in_ready, 0);
        k = 0;
        for (int i = 0; i < 8; i++) begin
            if (i < 2) cycle(1, 0, 4'd5, 4'd10, 0);
            else       cycle(0, 0, 0, 0, 0);
            if (alu_en) begin
                k++;
                check("stall_order", alu_a, k);
            end
        end
        check("stall_pulses", k, 5);

        // Full queue, one-cycle stall release with in_valid held.
        for (int i = 0; i < 4; i++) cycle(1, 1, 4'(i + 8), 4'(i), 1);
        check("full_count", count, 4);
        cycle(1, 1, 4'd7, 4'd7, 0);
        check("full_pop_no_push", count, 3);
        check("full_ready_next", in_ready, 1);
        cycle(1, 1, 4'd7, 4'd7, 1);
        check("full_refill", count, 4);
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 0);
        check("drained", count, 0);

        // Continuous stream of 10 commands.
        pulses = 0; run = 0; max_run = 0;
        for (int i = 0; i < 14; i++) begin
            if (i < 10) cycle(1, 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 0);
            else        cycle(0, 0, 0, 0, 0);
            if (i < 10) check("stream_count_le1", count <= 1, 1);
            if (y_valid) begin
                pulses++; run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
        end
        check("stream_pulses", pulses, 10);
        check("stream_consecutive", max_run, 10);

        // Asynchronous reset with 3 queued and one issuing.
        for (int i = 0; i < 4; i++) cycle(1, 0, 4'(i + 1), 4'(i + 2), 1);
        cycle(0, 0, 0, 0, 0);
        check("pre_rst_count", count, 3);
        check("pre_rst_en", alu_en, 1);
        #2 reset_n = 0;
        #1;
        model_reset();
        check("arst_count", count, 0);
        check("arst_en", alu_en, 0);
        check("arst_yv", y_valid, 0);
        check("arst_op", alu_op, 0);
        check("arst_a", alu_a, 0);
        check("arst_b", alu_b, 0);
        check("arst_ready", in_ready, 1);
        @(negedge clk);
        cycle(1, 0, 4'd1, 4'd1, 0);
        reset_n = 1;
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 0, 0, 0);
            check("post_rst_yv", y_valid, 0);
        end

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 1)),
                  4'($urandom), 4'($urandom), 1'($urandom_range(0, 99) < 30));
        end
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_queue.md
# alu_issue_queue

Upstream issue stage for the 4-bit add/subtract ALU. Accepts `{op, a, b}` commands over a valid/ready handshake and buffers them in a small FIFO. Issues one command per cycle to the ALU's `en/op/a/b` inputs. Produces `y_valid`, a strobe aligned with the cycle in which the ALU's registered `y` holds that command's result.

## Interface
Parameters:
- `DEPTH`, 4, FIFO entries; power of two, ≥ 2.
- `WIDTH`, 4, operand width; must match ALU operand width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  command present.
- `in_ready`  out  1  queue can accept; `= (count != DEPTH)`, combinational from `count`.
- `in_op`  in  1  0 = add, 1 = subtract.
- `in_a`, `in_b`  in  WIDTH  operands.
- `stall`  in  1  downstream hold; no issue while high.
- `alu_en`  out  1  registered; one-cycle strobe per issued command.
- `alu_op`  out  1  registered.
- `alu_a`, `alu_b`  out  WIDTH  registered.
- `y_valid`  out  1  registered; high in the cycle the ALU `y` is that command's result.
- `count`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Storage is a circular FIFO of `DEPTH` × (1+2·WIDTH) bits, with read pointer, write pointer and occupancy counter.
  - Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Push occurs at the edge where `in_valid && in_ready`. The entry is written at `wr_ptr`, then `wr_ptr` increments.
- Pop occurs at the edge where `count != 0 && !stall`. The head entry loads into `alu_op/alu_a/alu_b`, `alu_en` is set to 1, and `rd_ptr` increments.
- With no pop at an edge:
  - `alu_en` goes to 0.
  - `alu_op/alu_a/alu_b` hold their last values.
- `y_valid` is `alu_en` delayed by one register stage.
- Occupancy update:
  - Push and pop at the same edge: `count` unchanged.
  - Push only: `count` +1.
  - Pop only: `count` −1.
- Full (`count == DEPTH`):
  - `in_ready` = 0 and no push, even if a pop occurs at the same edge.
  - The slot freed by the pop becomes visible on `in_ready` in the next cycle.
- Empty (`count == 0`): no pop, `alu_en` = 0. The queue has no bypass path.
- `stall` is sampled at the clock edge only. Deasserting it allows a pop at the next edge.
- Commands issue in strict FIFO order. Operands pass through unmodified; no width change.
- Reset (`reset_n` low), applied immediately and independent of `clk`:
  - `count`, `rd_ptr`, `wr_ptr` = 0.
  - `alu_en`, `alu_op`, `alu_a`, `alu_b`, `y_valid` = 0.
  - FIFO contents need not be cleared.
  - During reset `in_ready` reads 1, but pushes are ignored.
- Reset mid-operation discards all queued and in-flight commands. `y_valid` is 0 from the first cycle of reset.
- Reset release must be synchronised externally. First push is permitted at the first edge after release.

## Timing
- Push at edge N → `count` increments after edge N.
- With the queue empty before edge N and `stall` low:
  - `alu_en` is high in the cycle after edge N+1.
  - The ALU latches at edge N+2.
  - `y_valid` is high in the cycle after edge N+2.
- Push-to-`y_valid` latency is therefore 3 edges.
- Sustained throughput is one command per cycle when `in_valid` is continuously high and `stall` is low. In this steady state `count` stays ≤ 1.
- `y_valid` is asserted for exactly one cycle per issued command. Back-to-back issues give back-to-back `y_valid`.
- `stall` rising at edge M: no pop at M, `alu_en` low after M. A `y_valid` already in flight from edge M-1 still asserts after M.

## Test plan
- Reset, then push (op=0, a=3, b=4) with `stall`=0:
  - `alu_en` high 2 edges after the push, with `alu_a`=3, `alu_b`=4.
  - `y_valid` high 1 edge later; ALU `y`=8'h07.
- Push (op=1, a=2, b=5) → `alu_op`=1; ALU `y`=8'hFD with `y_valid` high.
- Hold `stall`=1 and push 5 commands:
  - `count` reaches 4, `in_ready` goes 0, and the 5th command stays pending.
  - Release `stall`: 4 `alu_en` pulses in push order, then the 5th command is accepted and issued.
- Full queue, `in_valid`=1, single-cycle `stall` low:
  - Pop occurs but no push at that edge; `count`=3.
  - `in_ready`=1 next cycle; push accepted; `count`=4.
- Continuous stream of 10 commands with `stall`=0: 10 consecutive `y_valid` cycles in order, `count` ≤ 1 throughout.
- Assert `reset_n`=0 asynchronously with 3 entries queued and `alu_en`=1:
  - All outputs go 0 immediately and `count`=0.
  - After release, no `y_valid` occurs until new pushes.
